// File: rtl/mmu_resp_stage_pkg.sv
// Shared types and exception codes for the MMU response stage.
// Holds the buffered entry layout used by the stage's 2-entry skid FIFO.
package mmu_resp_stage_pkg;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_RSVD  = 2'd3
  } mem_op_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } mem_size_t;

  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  typedef struct packed {
    logic [31:0] paddr;
    logic [31:0] badv;
    logic [1:0]  mat;
    mem_op_t     op;
    mem_size_t   size;
    logic        excp;
    logic [5:0]  ecode;
  } mmu_resp_t;

  // Reserved size behaves as word.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lsb);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lsb[0];
      default:   return |lsb;
    endcase
  endfunction

endpackage

// File: rtl/mmu_exc_decode.sv
// Combinational LoongArch memory exception decode (first match wins).
// TLB-derived exceptions are only produced when MMU_TLB_EXC_EN is defined.
module mmu_exc_decode
  import mmu_resp_stage_pkg::*;
(
  input  mem_op_t    i_op,
  input  mem_size_t  i_size,
  input  logic [1:0] i_vaddr_lsb,
  input  logic       i_page_fault,
  input  logic       i_page_invalid,
  input  logic       i_page_dirty,
  input  logic       i_plv_fault,
  output logic       o_excp,
  output logic [5:0] o_ecode
);

  // NOTE: outputs get defaults before any branch so no path leaves them unassigned (no latch).
  always_comb begin
    o_excp  = 1'b0;
    o_ecode = '0;
    if (i_op == OP_FETCH && i_vaddr_lsb != 2'b00) begin
      o_excp  = 1'b1;
      o_ecode = ECODE_ADE;
    end else if (i_op != OP_FETCH && is_misaligned(i_size, i_vaddr_lsb)) begin
      o_excp  = 1'b1;
      o_ecode = ECODE_ALE;
    end
`ifdef MMU_TLB_EXC_EN
    else if (i_page_fault) begin
      o_excp  = 1'b1;
      o_ecode = ECODE_TLBR;
    end else if (i_page_invalid) begin
      o_excp = 1'b1;
      case (i_op)
        OP_FETCH: o_ecode = ECODE_PIF;
        OP_STORE: o_ecode = ECODE_PIS;
        default:  o_ecode = ECODE_PIL;
      endcase
    end else if (i_plv_fault) begin
      o_excp  = 1'b1;
      o_ecode = ECODE_PPI;
    end else if (i_op == OP_STORE && i_page_dirty) begin
      o_excp  = 1'b1;
      o_ecode = ECODE_PME;
    end
`endif
  end

`ifndef MMU_TLB_EXC_EN
  logic w_unused_flags;
  assign w_unused_flags = ^{i_page_fault, i_page_invalid, i_page_dirty, i_plv_fault};
`endif

endmodule

// File: rtl/mmu_resp_stage.sv
// Registered MMU response stage: computes paddr/exception, buffers in a 2-entry skid FIFO.
// Optional TLB exceptions controlled by MMU_TLB_EXC_EN (see mmu_exc_decode).
module mmu_resp_stage
  import mmu_resp_stage_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_vaddr,
  input  logic [1:0]       in_op,
  input  logic [1:0]       in_size,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [19:0]      in_ptag,
  input  logic [1:0]       in_mat,
  input  logic             in_page_fault,
  input  logic             in_page_invalid,
  input  logic             in_page_dirty,
  input  logic             in_plv_fault,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_paddr,
  output logic [1:0]       out_mat,
  output logic [1:0]       out_op,
  output logic [1:0]       out_size,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_excp,
  output logic [5:0]       out_ecode,
  output logic [31:0]      out_badv
);

  mmu_resp_t        r_mem     [2];
  logic [TAG_W-1:0] r_tag_mem [2];
  logic             r_head, r_tail, r_in_ready;
  logic [1:0]       r_count, w_count_nxt;
  logic             w_push, w_pop, w_excp;
  logic [5:0]       w_ecode;
  mmu_resp_t        w_entry, w_head;

  mmu_exc_decode u_exc_decode (
    .i_op           (mem_op_t'(in_op)),
    .i_size         (mem_size_t'(in_size)),
    .i_vaddr_lsb    (in_vaddr[1:0]),
    .i_page_fault   (in_page_fault),
    .i_page_invalid (in_page_invalid),
    .i_page_dirty   (in_page_dirty),
    .i_plv_fault    (in_plv_fault),
    .o_excp         (w_excp),
    .o_ecode        (w_ecode)
  );

  always_comb begin
    w_entry.paddr = {in_ptag, in_vaddr[11:0]};
    w_entry.badv  = in_vaddr;
    w_entry.mat   = in_mat;
    w_entry.op    = mem_op_t'(in_op);
    w_entry.size  = mem_size_t'(in_size);
    w_entry.excp  = w_excp;
    w_entry.ecode = w_ecode;
  end

  assign w_push = in_valid & r_in_ready & ~flush;
  assign w_pop  = out_valid & out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
    if (flush) w_count_nxt = 2'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
      if (flush) begin
        r_head <= 1'b0;
        r_tail <= 1'b0;
      end else begin
        if (w_push) r_tail <= ~r_tail;
        if (w_pop)  r_head <= ~r_head;
      end
    end
  end

  // NOTE: payload storage is left unreset; out_valid and the excp/ecode gating hide stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail]     <= w_entry;
      r_tag_mem[r_tail] <= in_tag;
    end
  end

  assign w_head    = r_mem[r_head];
  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_paddr = w_head.paddr;
  assign out_badv  = w_head.badv;
  assign out_mat   = w_head.mat;
  assign out_op    = w_head.op;
  assign out_size  = w_head.size;
  assign out_tag   = r_tag_mem[r_head];
  assign out_excp  = out_valid & w_head.excp;
  assign out_ecode = out_valid ? w_head.ecode : 6'd0;

endmodule

// File: tb/tb_mmu_resp_stage.sv
// Scoreboard bench for mmu_resp_stage: driver pushes expected responses, monitor pops and compares.
// Expected exception codes follow MMU_TLB_EXC_EN when it is defined for the build.
module tb_mmu_resp_stage;

  typedef struct {
    logic [31:0] vaddr;
    logic [1:0]  op;
    logic [1:0]  size;
    logic [19:0] ptag;
    logic [1:0]  mat;
    logic [3:0]  flags;   // {fault, invalid, dirty, plv}
    logic [5:0]  ec_on;
    logic [5:0]  ec_off;
  } vec_t;

  typedef struct {
    logic [31:0] paddr;
    logic [31:0] badv;
    logic        excp;
    logic [5:0]  ecode;
    logic [13:0] fwd;     // {tag, op, size, mat}
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_vaddr = '0;
  logic [1:0]  in_op = '0, in_size = '0, in_mat = '0;
  logic [7:0]  in_tag = '0;
  logic [19:0] in_ptag = '0;
  logic        in_page_fault = 1'b0, in_page_invalid = 1'b0;
  logic        in_page_dirty = 1'b0, in_plv_fault = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_paddr, out_badv;
  logic [1:0]  out_mat, out_op, out_size;
  logic [7:0]  out_tag;
  logic        out_excp;
  logic [5:0]  out_ecode;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic [7:0] tag_ctr = 8'h10;
  vec_t vecs[16];

  mmu_resp_stage #(.TAG_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_vaddr(in_vaddr),
    .in_op(in_op), .in_size(in_size), .in_tag(in_tag), .in_ptag(in_ptag),
    .in_mat(in_mat), .in_page_fault(in_page_fault), .in_page_invalid(in_page_invalid),
    .in_page_dirty(in_page_dirty), .in_plv_fault(in_plv_fault),
    .out_valid(out_valid), .out_ready(out_ready), .out_paddr(out_paddr),
    .out_mat(out_mat), .out_op(out_op), .out_size(out_size), .out_tag(out_tag),
    .out_excp(out_excp), .out_ecode(out_ecode), .out_badv(out_badv)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] va, input logic [1:0] op, input logic [1:0] sz,
                              input logic [19:0] pt, input logic [1:0] mat, input logic [3:0] fl,
                              input logic [5:0] on, input logic [5:0] off);
    vec_t v;
    v.vaddr = va; v.op = op; v.size = sz; v.ptag = pt; v.mat = mat;
    v.flags = fl; v.ec_on = on; v.ec_off = off;
    return v;
  endfunction

  // Drives one request and waits (bounded) until it is accepted; returns cycles spent waiting.
  task automatic drive(input vec_t v, output int waits);
    exp_t e;
    bit   accepted = 1'b0;
    waits = 0;
    in_vaddr = v.vaddr; in_op = v.op; in_size = v.size; in_ptag = v.ptag; in_mat = v.mat;
    {in_page_fault, in_page_invalid, in_page_dirty, in_plv_fault} = v.flags;
    in_tag = tag_ctr;
    in_valid = 1'b1;
    e.paddr = {v.ptag, v.vaddr[11:0]};
    e.badv  = v.vaddr;
`ifdef MMU_TLB_EXC_EN
    e.ecode = v.ec_on;
`else
    e.ecode = v.ec_off;
`endif
    e.excp = (e.ecode != 6'd0);
    e.fwd  = {tag_ctr, v.op, v.size, v.mat};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        sb_q.push_back(e);
        tag_ctr = tag_ctr + 8'd1;
        accepted = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      waits++;
      @(posedge clk);
      #1;
    end
    if (!accepted) check("drive_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  // Monitor: compares every transfer against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && !flush && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("paddr", out_paddr, e.paddr);
          check("excp",  out_excp,  e.excp);
          check("ecode", out_ecode, e.ecode);
          check("badv",  out_badv,  e.badv);
          check("fwd",   {out_tag, out_op, out_size, out_mat}, e.fwd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    //               vaddr         op    size  ptag      mat   flags    on     off
    vecs[0]  = mk(32'h1000_0004, 2'd1, 2'd2, 20'h80001, 2'd1, 4'b0000, 6'h00, 6'h00);
    vecs[1]  = mk(32'h2000_0010, 2'd2, 2'd2, 20'h12345, 2'd0, 4'b0010, 6'h04, 6'h00);
    vecs[2]  = mk(32'h2000_0010, 2'd2, 2'd2, 20'h12345, 2'd0, 4'b0110, 6'h02, 6'h00);
    vecs[3]  = mk(32'h0000_3001, 2'd1, 2'd1, 20'hABCDE, 2'd2, 4'b1000, 6'h09, 6'h09);
    vecs[4]  = mk(32'h0000_4002, 2'd0, 2'd2, 20'h00044, 2'd1, 4'b1000, 6'h08, 6'h08);
    vecs[5]  = mk(32'h0000_5000, 2'd0, 2'd2, 20'h00055, 2'd1, 4'b0100, 6'h03, 6'h00);
    vecs[6]  = mk(32'h0000_6003, 2'd1, 2'd0, 20'h00066, 2'd3, 4'b0101, 6'h01, 6'h00);
    vecs[7]  = mk(32'h0000_7001, 2'd1, 2'd0, 20'h00077, 2'd0, 4'b0011, 6'h07, 6'h00);
    vecs[8]  = mk(32'h0000_8005, 2'd2, 2'd0, 20'h00088, 2'd0, 4'b0011, 6'h07, 6'h00);
    vecs[9]  = mk(32'h0000_9002, 2'd3, 2'd2, 20'h00099, 2'd1, 4'b0000, 6'h09, 6'h09);
    vecs[10] = mk(32'h0000_A002, 2'd1, 2'd3, 20'h000AA, 2'd1, 4'b0000, 6'h09, 6'h09);
    vecs[11] = mk(32'h0000_B002, 2'd1, 2'd1, 20'h000BB, 2'd1, 4'b1111, 6'h3F, 6'h00);
    vecs[12] = mk(32'h0000_C001, 2'd2, 2'd1, 20'h000CC, 2'd1, 4'b1111, 6'h09, 6'h09);
    vecs[13] = mk(32'h0000_E001, 2'd0, 2'd0, 20'h000EE, 2'd1, 4'b0000, 6'h08, 6'h08);
    vecs[14] = mk(32'hFFFF_F00C, 2'd2, 2'd2, 20'hFFFFF, 2'd2, 4'b0000, 6'h00, 6'h00);
    vecs[15] = mk(32'h0000_D000, 2'd2, 2'd2, 20'h000DD, 2'd0, 4'b0100, 6'h02, 6'h00);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_excp",  out_excp,  1'b0);
    check("rst_out_ecode", out_ecode, 6'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // First request: visible the cycle after acceptance
    drive(vecs[0], w);
    check("latency_out_valid", out_valid, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Back-to-back stream with out_ready held high: no stalls expected
    for (int i = 1; i < 15; i++) begin
      drive(vecs[i], w);
      check("tput_wait", w, 0);
    end
    repeat (3) @(posedge clk); #1;
    check("drain_empty", out_valid, 1'b0);

    // Backpressure: two accepted, third held off until downstream drains
    out_ready = 1'b0;
    drive(vecs[0], w);
    check("bp_ready_cnt1", in_ready, 1'b1);
    drive(vecs[3], w);
    check("bp_ready_cnt2", in_ready, 1'b0);
    in_vaddr = vecs[5].vaddr; in_op = vecs[5].op; in_size = vecs[5].size;
    in_ptag = vecs[5].ptag; in_valid = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("bp_ready_hold", in_ready, 1'b0);
    check("bp_head_stable", out_paddr, {vecs[0].ptag, vecs[0].vaddr[11:0]});
    out_ready = 1'b1;
    drive(vecs[5], w);
    repeat (3) @(posedge clk); #1;
    check("bp_drained", out_valid, 1'b0);

    // Flush at count 2 with a same-cycle input
    out_ready = 1'b0;
    drive(vecs[1], w);
    drive(vecs[2], w);
    in_vaddr = vecs[7].vaddr; in_ptag = vecs[7].ptag; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    sb_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_out_valid", out_valid, 1'b0);
    check("flush2_in_ready",  in_ready,  1'b1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("flush2_no_ghost", out_valid, 1'b0);

    // Flush at count 1 while in_ready=1: the same-cycle push must be discarded
    out_ready = 1'b0;
    drive(vecs[4], w);
    in_vaddr = vecs[8].vaddr; in_ptag = vecs[8].ptag; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    sb_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("flush1_no_ghost", out_valid, 1'b0);

    // Post-flush traffic still flows in order
    drive(vecs[15], w);
    drive(vecs[9], w);
    repeat (3) @(posedge clk); #1;

    // Asynchronous reset with one entry buffered
    out_ready = 1'b0;
    drive(vecs[6], w);
    check("pre_rst_valid", out_valid, 1'b1);
    #2;
    reset = 1'b1;
    sb_q.delete();
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready",  in_ready,  1'b1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("post_rst_empty", out_valid, 1'b0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_resp_stage.md
# mmu_resp_stage

Registered pipeline stage directly downstream of address translation. It takes one memory request per cycle along with its translated tag and page-check flags. It derives the physical address and the LoongArch memory exception code, then hands the request to the cache/LSU through a 2-entry skid buffer with valid/ready flow control. It isolates the combinational translation path from the cache request path.

## Interface
- TAG_W, default 8: width of opaque sideband (ROB id, etc.) carried with each request
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  drop all buffered requests and any same-cycle input
- in_valid  in  1  upstream request valid
- in_ready  out  1  stage can accept; registered, equals "buffer not full"
- in_vaddr  in  32  virtual address
- in_op  in  2  0 fetch, 1 load, 2 store, 3 reserved (treated as load)
- in_size  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
- in_tag  in  TAG_W  sideband
- in_ptag  in  20  translated PA[31:12]
- in_mat  in  2  memory access type
- in_page_fault  in  1  TLB miss
- in_page_invalid  in  1  V bit clear
- in_page_dirty  in  1  high when page D bit is clear (write would modify a clean page)
- in_plv_fault  in  1  current PLV exceeds page PLV
- out_valid  out  1  request available
- out_ready  in  1  downstream accepts
- out_paddr  out  32  {ptag, vaddr[11:0]}
- out_mat, out_op, out_size, out_tag  out  2/2/2/TAG_W  forwarded fields
- out_excp  out  1  request carries an exception; downstream must not access memory
- out_ecode  out  6  exception code, 0 when out_excp=0
- out_badv  out  32  faulting vaddr, equals in_vaddr

## Operation
- Buffer: 2-entry FIFO, head/tail pointers 1 bit each, count 0..2. Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready.
- in_ready = (count != 2), registered from the next count. Push and pop in the same cycle at count 2 is impossible because in_ready=0. At count 1, push and pop together keep count 1.
- Exception priority, first match wins, evaluated on input before write:
  - Fetch with vaddr[1:0]!=0 → ADE 0x08.
  - Load/store misaligned: half with vaddr[0], word with vaddr[1:0]!=0 → ALE 0x09.
  - page_fault → TLBR 0x3F.
  - page_invalid → PIF 0x03 (fetch), PIL 0x01 (load), PIS 0x02 (store).
  - plv_fault → PPI 0x07.
  - store & page_dirty → PME 0x04.
- Entries store computed paddr/excp/ecode. Nothing is recomputed at output.
- flush: count←0 and pointers←0 next cycle. A simultaneous push is discarded. out_valid may be high in the flush cycle, and downstream ignores it.

## Timing
- Reset: count 0, pointers 0, out_valid 0, in_ready 1. Payload registers are don't-care. out_ecode/out_excp are driven 0 while out_valid=0.
- Latency: request accepted in cycle N appears at output in cycle N+1 at the earliest.
- out_valid = (count != 0). Head payload stays stable while out_valid & ~out_ready.
- Throughput: 1 request/cycle when out_ready is held high.
- Reset asserted mid-operation clears the stage immediately (asynchronous). No partial request survives.

## Configuration
- MMU_TLB_EXC_EN defined: TLBR/PIx/PPI/PME are generated per the priority above.
- MMU_TLB_EXC_EN undefined: the four TLB flag inputs are ignored, and only ADE/ALE are produced. The TLB flag inputs remain as ports but are unused.

## Structure
- Shared package holds `mem_op_t`, `mem_size_t`, the ecode localparams (ECODE_ADE, ECODE_ALE, ECODE_TLBR, ECODE_PIL, ECODE_PIS, ECODE_PIF, ECODE_PME, ECODE_PPI), and the buffered entry struct `mmu_resp_t`.
- One sub-module, `mmu_exc_decode`, is combinational: flags, op, size, vaddr → excp, ecode. The FIFO lives in the top module.

## Test plan
- Word load, vaddr 0x1000_0004, ptag 0x8_0001, all flags 0, out_ready=1 → next cycle out_valid=1, paddr 0x8000_1004, excp 0.
- Store, vaddr 0x2000_0010, page_dirty=1, page_invalid=0 → ecode 0x04. Same request with page_invalid=1 → ecode 0x02. With MMU_TLB_EXC_EN undefined → excp 0.
- Half load, vaddr 0x3001, page_fault=1 → ecode 0x09 (ALE beats TLBR), badv 0x0000_3001.
- out_ready=0, push 3 consecutive requests → two accepted, in_ready=0 from cycle 2. Releasing out_ready → FIFO order preserved and the third is accepted.
- Count 2, flush with in_valid=1 → next cycle out_valid=0, in_ready=1, dropped input never appears.
- Reset asserted with count 1 → out_valid falls without waiting for a clock edge, in_ready=1.
